board_writer: RTL and testbench

Board-state owner and move sequencer for the Connect Four datapath. Accepts column-drop requests and computes the landing row from per-column fill counts. Writes the 42-bit occupancy and owner registers, then presents the placed location and height to the combinational win checker. One cycle later it samples the checker's result and reports OK, invalid, win or draw, toggling the player on a normal move.

---
 rtl/c4_pkg.sv | 23 ++
 rtl/column_heights.sv | 39 +++
 rtl/board_writer.sv | 149 ++++++++++++++
 tb/tb_board_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/c4_pkg.sv
// Shared Connect Four geometry, status/state encodings and cell indexing.
package c4_pkg;

    localparam int NUM_COLS = 7;
    localparam int NUM_ROWS = 6;
    localparam int CELLS    = NUM_COLS * NUM_ROWS;

    localparam logic [1:0] ST_OK      = 2'b00;
    localparam logic [1:0] ST_INVALID = 2'b01;
    localparam logic [1:0] ST_WIN     = 2'b10;
    localparam logic [1:0] ST_DRAW    = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WRITE = 2'd1,
        S_CHECK = 2'd2
    } state_t;

    function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
        return ({3'b000, row} * 6'd7) + {3'b000, col};
    endfunction

endpackage

// File: rtl/column_heights.sv
// Per-column fill counters, saturating at NUM_ROWS, with a synchronous clear.
import c4_pkg::*;

module column_heights (
    input  logic                         clock,
    input  logic                         clear,
    input  logic                         inc,
    input  logic [2:0]                   inc_col,
    output logic [NUM_COLS-1:0][2:0]     fill,
    output logic [NUM_COLS-1:0]          full
);

    logic [NUM_COLS-1:0][2:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            if (inc && (inc_col == 3'(c)) && (cnt_q[c] != 3'(NUM_ROWS))) begin
                cnt_d[c] = cnt_q[c] + 3'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        fill = cnt_q;
        for (int c = 0; c < NUM_COLS; c++) begin
            full[c] = (cnt_q[c] == 3'(NUM_ROWS));
        end
    end

endmodule

// File: rtl/board_writer.sv
// Connect Four board owner: validates drops, writes occupancy/owner bits,
// then samples the external win checker and reports the move result.
import c4_pkg::*;

module board_writer (
    input  logic               clock,
    input  logic               reset,
    input  logic               new_game,
    input  logic               move_valid,
    input  logic [2:0]         move_col,
    output logic               move_ready,
    output logic               move_done,
    output logic [1:0]         move_status,
    output logic [2:0]         location,
    output logic [2:0]         height,
    output logic [CELLS-1:0]   player_register,
    output logic [CELLS-1:0]   onoff_register,
    output logic               player,
    output logic               game_over,
    input  logic               wongame
);

    state_t             state_q, state_d;
    logic [2:0]         col_q, col_d;
    logic               done_q, done_d;
    logic [1:0]         status_q, status_d;
    logic [2:0]         loc_q, loc_d;
    logic [2:0]         hgt_q, hgt_d;
    logic [CELLS-1:0]   owner_q, owner_d;
    logic [CELLS-1:0]   occ_q, occ_d;
    logic               player_q, player_d;
    logic               over_q, over_d;
    logic [5:0]         moves_q, moves_d;

    logic                     clear;
    logic                     inc;
    logic [NUM_COLS-1:0][2:0] fill;
    logic [NUM_COLS-1:0]      full;
    logic [7:0][2:0]          fill_ext;
    logic [7:0]               full_ext;
    logic [5:0]               idx;

    assign clear = reset | new_game;
    assign inc   = (state_q == S_WRITE);

    // Column 7 is padded as permanently full so an illegal column rejects.
    assign fill_ext = {3'd0, fill};
    assign full_ext = {1'b1, full};
    assign idx      = cell_idx(fill_ext[col_q], col_q);

    column_heights u_heights (
        .clock   (clock),
        .clear   (clear),
        .inc     (inc),
        .inc_col (col_q),
        .fill    (fill),
        .full    (full)
    );

    always_comb begin
        state_d  = state_q;
        col_d    = col_q;
        done_d   = 1'b0;
        status_d = status_q;
        loc_d    = loc_q;
        hgt_d    = hgt_q;
        owner_d  = owner_q;
        occ_d    = occ_q;
        player_d = player_q;
        over_d   = over_q;
        moves_d  = moves_q;
        case (state_q)
            S_IDLE: begin
                if (move_valid) begin
                    if (over_q || full_ext[move_col]) begin
                        done_d   = 1'b1;
                        status_d = ST_INVALID;
                    end else begin
                        col_d   = move_col;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                occ_d[idx]   = 1'b1;
                owner_d[idx] = player_q;
                loc_d        = col_q;
                hgt_d        = fill_ext[col_q];
                moves_d      = moves_q + 6'd1;
                state_d      = S_CHECK;
            end
            S_CHECK: begin
                done_d  = 1'b1;
                state_d = S_IDLE;
                // A win on the final cell outranks the draw.
                if (wongame) begin
                    status_d = ST_WIN;
                    over_d   = 1'b1;
                end else if (moves_q == 6'(CELLS)) begin
                    status_d = ST_DRAW;
                    over_d   = 1'b1;
                end else begin
                    status_d = ST_OK;
                    player_d = ~player_q;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            state_q  <= S_IDLE;
            col_q    <= '0;
            done_q   <= 1'b0;
            status_q <= '0;
            loc_q    <= '0;
            hgt_q    <= '0;
            owner_q  <= '0;
            occ_q    <= '0;
            player_q <= 1'b0;
            over_q   <= 1'b0;
            moves_q  <= '0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            done_q   <= done_d;
            status_q <= status_d;
            loc_q    <= loc_d;
            hgt_q    <= hgt_d;
            owner_q  <= owner_d;
            occ_q    <= occ_d;
            player_q <= player_d;
            over_q   <= over_d;
            moves_q  <= moves_d;
        end
    end

    assign move_ready      = (state_q == S_IDLE);
    assign move_done       = done_q;
    assign move_status     = status_q;
    assign location        = loc_q;
    assign height          = hgt_q;
    assign player_register = owner_q;
    assign onoff_register  = occ_q;
    assign player          = player_q;
    assign game_over       = over_q;

endmodule

// File: tb/tb_board_writer.sv
// Directed bench for board_writer: vector table plus hand-written sequences,
// checked against an independent board model kept by the bench.
module tb_board_writer;
    import c4_pkg::*;

    logic        clock = 1'b0;
    logic        reset, new_game, move_valid, wongame;
    logic [2:0]  move_col;
    logic        move_ready, move_done, player, game_over;
    logic [1:0]  move_status;
    logic [2:0]  location, height;
    logic [41:0] player_register, onoff_register;

    board_writer dut (
        .clock           (clock),
        .reset           (reset),
        .new_game        (new_game),
        .move_valid      (move_valid),
        .move_col        (move_col),
        .move_ready      (move_ready),
        .move_done       (move_done),
        .move_status     (move_status),
        .location        (location),
        .height          (height),
        .player_register (player_register),
        .onoff_register  (onoff_register),
        .player          (player),
        .game_over       (game_over),
        .wongame         (wongame)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    logic [41:0] ob, pb;
    int          hgt [7];
    logic        m_player, m_over;

    typedef struct {
        logic [2:0] col;
        logic       win;
        logic [1:0] st;
    } vec_t;

    vec_t vecs [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic model_clear();
        ob = '0;
        pb = '0;
        for (int c = 0; c < 7; c++) hgt[c] = 0;
        m_player = 1'b0;
        m_over   = 1'b0;
    endtask

    task automatic check_clear(input string tag);
        chk({tag, "_onoff"},  onoff_register, 64'd0);
        chk({tag, "_owner"},  player_register, 64'd0);
        chk({tag, "_loc"},    location, 64'd0);
        chk({tag, "_height"}, height, 64'd0);
        chk({tag, "_player"}, player, 64'd0);
        chk({tag, "_over"},   game_over, 64'd0);
        chk({tag, "_done"},   move_done, 64'd0);
        chk({tag, "_status"}, move_status, 64'd0);
        chk({tag, "_ready"},  move_ready, 64'd1);
    endtask

    task automatic do_clear();
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        check_clear("newgame");
    endtask

    task automatic do_move(input logic [2:0] col, input logic win, input logic [1:0] st);
        int idx;
        move_col   = col;
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        if (st == ST_INVALID) begin
            chk("inv_done",   move_done, 64'd1);
            chk("inv_status", move_status, {62'd0, ST_INVALID});
            chk("inv_ready",  move_ready, 64'd1);
            chk("inv_onoff",  onoff_register, ob);
            chk("inv_owner",  player_register, pb);
            chk("inv_player", player, m_player);
        end else begin
            chk("write_done",  move_done, 64'd0);
            chk("write_ready", move_ready, 64'd0);
            step();
            idx = hgt[col] * 7 + int'(col);
            ob[idx] = 1'b1;
            pb[idx] = m_player;
            hgt[col]++;
            chk("e1_onoff",  onoff_register, ob);
            chk("e1_owner",  player_register, pb);
            chk("e1_loc",    location, col);
            chk("e1_height", height, hgt[col] - 1);
            chk("e1_done",   move_done, 64'd0);
            wongame = win;
            step();
            wongame = 1'b0;
            if (st == ST_OK) m_player = ~m_player;
            else m_over = 1'b1;
            chk("e2_done",   move_done, 64'd1);
            chk("e2_status", move_status, {62'd0, st});
            chk("e2_ready",  move_ready, 64'd1);
            chk("e2_player", player, m_player);
        end
        chk("over", game_over, m_over);
    endtask

    initial begin
        logic [41:0] col0_mask;
        logic [41:0] all_ones;
        col0_mask = 42'h0;
        for (int r = 0; r < 6; r++) col0_mask[r*7] = 1'b1;
        all_ones = '1;

        reset = 1'b1; new_game = 1'b0; move_valid = 1'b0; move_col = 3'd0; wongame = 1'b0;
        model_clear();
        step();
        step();
        reset = 1'b0;
        check_clear("reset");

        // Tests 1-4: first drop, column fill-up, illegal column, forced win.
        vecs.push_back('{3'd3, 1'b0, ST_OK});
        for (int i = 0; i < 6; i++) vecs.push_back('{3'd0, 1'b0, ST_OK});
        vecs.push_back('{3'd0, 1'b0, ST_INVALID});
        vecs.push_back('{3'd7, 1'b0, ST_INVALID});
        vecs.push_back('{3'd1, 1'b0, ST_OK});
        vecs.push_back('{3'd2, 1'b1, ST_WIN});
        vecs.push_back('{3'd4, 1'b0, ST_INVALID});
        vecs.push_back('{3'd6, 1'b0, ST_INVALID});

        for (int i = 0; i < vecs.size(); i++) begin
            do_move(vecs[i].col, vecs[i].win, vecs[i].st);
            if (i == 0) begin
                chk("t1_onoff", onoff_register, 64'h8);
                chk("t1_owner", player_register, 64'h0);
                chk("t1_player", player, 64'd1);
            end
            if (i == 6) chk("t2_col0_bits", onoff_register & col0_mask, col0_mask);
        end
        chk("t4_over_final", game_over, 64'd1);

        // Test 5a: 42 moves fill the board, final one is DRAW.
        do_clear();
        for (int i = 0; i < 42; i++) do_move(3'(i / 6), 1'b0, (i == 41) ? ST_DRAW : ST_OK);
        chk("t5_full_board", onoff_register, all_ones);
        do_move(3'd0, 1'b0, ST_INVALID);

        // Test 5b: win on the 42nd move outranks draw.
        do_clear();
        for (int i = 0; i < 42; i++) do_move(3'(i / 6), i == 41, (i == 41) ? ST_WIN : ST_OK);
        chk("t5_win_board", onoff_register, all_ones);

        // Test 6: new_game during WRITE aborts the move with no done pulse.
        do_clear();
        do_move(3'd1, 1'b0, ST_OK);
        move_col   = 3'd5;
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        chk("t6_in_write", move_ready, 64'd0);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        model_clear();
        check_clear("t6_abort");
        step();
        chk("t6_no_done", move_done, 64'd0);
        chk("t6_ready", move_ready, 64'd1);

        // New game during CHECK also aborts cleanly.
        move_col   = 3'd2;
        move_valid = 1'b1;
        step();
        move_valid = 1'b0;
        step();
        wongame  = 1'b1;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        wongame  = 1'b0;
        check_clear("t6_check_abort");
        step();
        chk("t6_check_no_done", move_done, 64'd0);
        do_move(3'd2, 1'b0, ST_OK);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
